// File: rtl/trace_packer.sv
// Trace packer: packs lane-wide trace samples into logger words (trace mode) and
// serialises logger words back into lane-wide samples (streaming mode).
// Optional TRACE_PACKER_OVERFLOW_CNT_EN adds a saturating dropped-word counter.
module trace_packer #(
   parameter int unsigned TRB_WIDTH       = 32,
   parameter int unsigned TRB_MAX_TRACES  = 8,
   parameter int unsigned TRB_NTRACE_BITS = 3
) (
   input  logic                         CLK_I,
   input  logic                         RST_I,
   input  logic                         MODE_I,
   input  logic [TRB_NTRACE_BITS-1:0]   NTRACE_I,
   input  logic [TRB_MAX_TRACES-1:0]    TRACE_I,
   input  logic                         TRACE_VALID_I,
   input  logic                         TRG_I,
   input  logic                         TRG_DELAYED_I,
   output logic                         STORE_O,
   output logic [TRB_WIDTH-1:0]         DATA_O,
   input  logic                         STORE_PERM_I,
   output logic                         TRG_EVENT_O,
   output logic [$clog2(TRB_WIDTH)-1:0] EVENT_POS_O,
   output logic                         LOAD_REQUEST_O,
   input  logic                         LOAD_GRANT_I,
   input  logic [TRB_WIDTH-1:0]         DATA_I,
   output logic [TRB_MAX_TRACES-1:0]    STREAM_O,
   output logic                         STREAM_VALID_O,
   input  logic                         STREAM_READY_I,
   output logic                         OVERFLOW_O
`ifdef TRACE_PACKER_OVERFLOW_CNT_EN
   ,
   output logic [15:0]                  OVERFLOW_CNT_O
`endif
);

   localparam int unsigned PW      = $clog2(TRB_WIDTH);
   localparam int unsigned LW      = PW + 1;
   localparam int unsigned LOG_MAX = $clog2(TRB_MAX_TRACES);

   localparam logic [1:0] S_EMPTY = 2'd0;
   localparam logic [1:0] S_WAIT  = 2'd1;
   localparam logic [1:0] S_FULL  = 2'd2;

   logic [1:0]                 state_q, state_d;
   logic [PW-1:0]              pos_q, pos_d;
   logic [TRB_WIDTH-1:0]       word_q, word_d;
   logic                       mode_q;
   logic [TRB_NTRACE_BITS-1:0] ntrace_q;
   logic                       store_q, store_d;
   logic [TRB_WIDTH-1:0]       data_q, data_d;
   logic                       trg_q, trg_d;
   logic [PW-1:0]              evpos_q, evpos_d;
   logic                       req_q, req_d;
   logic                       valid_q, valid_d;
   logic [TRB_MAX_TRACES-1:0]  stream_q, stream_d;
   logic                       ovf_q, ovf_d;
   logic                       ovf_inc;

   logic [LW-1:0]              lanes;
   logic [TRB_MAX_TRACES-1:0]  lane_mask;
   logic                       cfg_change;
   logic                       accept;
   logic [PW-1:0]              pos_adv;
   logic                       wrap;
   logic [TRB_WIDTH-1:0]       sample_sh;
   logic [TRB_WIDTH-1:0]       mask_sh;
   logic [TRB_WIDTH-1:0]       merged;

   // Lane count and mask from the registered lane setting.
   always_comb begin
      lanes     = '0;
      lane_mask = '0;
      if (ntrace_q >= TRB_NTRACE_BITS'(LOG_MAX))
         lanes = LW'(TRB_MAX_TRACES);
      else
         lanes = LW'(1) << ntrace_q;
      for (int unsigned i = 0; i < TRB_MAX_TRACES; i++)
         lane_mask[i] = (LW'(i) < lanes);
   end

   // A word completes when the pointer wraps back to bit 0.
   always_comb begin
      cfg_change = (MODE_I != mode_q) || (NTRACE_I != ntrace_q);
      accept     = TRACE_VALID_I & ~TRG_DELAYED_I;
      pos_adv    = pos_q + PW'(lanes);
      wrap       = (pos_adv == '0);
      sample_sh  = TRB_WIDTH'(TRACE_I & lane_mask) << pos_q;
      mask_sh    = TRB_WIDTH'(lane_mask) << pos_q;
      merged     = (word_q & ~mask_sh) | sample_sh;
   end

   always_comb begin
      state_d  = state_q;
      pos_d    = pos_q;
      word_d   = word_q;
      store_d  = 1'b0;
      data_d   = data_q;
      trg_d    = trg_q;
      evpos_d  = evpos_q;
      ovf_d    = ovf_q;
      ovf_inc  = 1'b0;
      req_d    = 1'b0;
      valid_d  = 1'b0;
      stream_d = '0;

      if (cfg_change) begin
         state_d = S_EMPTY;
         pos_d   = '0;
         word_d  = '0;
      end else if (!mode_q) begin
         state_d = S_EMPTY;
         if (accept) begin
            word_d = merged;
            pos_d  = pos_adv;
            if (TRG_I && !trg_q) begin
               trg_d   = 1'b1;
               evpos_d = pos_q;
            end
            if (wrap) begin
               word_d = '0;
               if (STORE_PERM_I) begin
                  store_d = 1'b1;
                  data_d  = merged;
               end else begin
                  ovf_d   = 1'b1;
                  ovf_inc = 1'b1;
               end
            end
         end
      end else begin
         case (state_q)
            S_EMPTY: if (req_q) state_d = S_WAIT;
            S_WAIT: begin
               if (LOAD_GRANT_I) begin
                  word_d  = DATA_I;
                  pos_d   = '0;
                  state_d = S_FULL;
               end
            end
            S_FULL: begin
               if (STREAM_READY_I) begin
                  pos_d = pos_adv;
                  if (wrap) state_d = S_EMPTY;
               end
            end
            default: state_d = S_EMPTY;
         endcase
      end

      // Request is asserted for exactly the cycle spent in S_EMPTY while streaming.
      if (mode_q && !cfg_change) begin
         req_d   = (state_d == S_EMPTY);
         valid_d = (state_d == S_FULL);
      end
      if (valid_d)
         stream_d = TRB_MAX_TRACES'(word_d >> pos_d) & lane_mask;
   end

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         state_q  <= S_EMPTY;
         pos_q    <= '0;
         word_q   <= '0;
         mode_q   <= MODE_I;
         ntrace_q <= NTRACE_I;
         store_q  <= 1'b0;
         data_q   <= '0;
         trg_q    <= 1'b0;
         evpos_q  <= '0;
         req_q    <= 1'b0;
         valid_q  <= 1'b0;
         stream_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pos_q    <= pos_d;
         word_q   <= word_d;
         mode_q   <= MODE_I;
         ntrace_q <= NTRACE_I;
         store_q  <= store_d;
         data_q   <= data_d;
         trg_q    <= trg_d;
         evpos_q  <= evpos_d;
         req_q    <= req_d;
         valid_q  <= valid_d;
         stream_q <= stream_d;
         ovf_q    <= ovf_d;
      end
   end

`ifdef TRACE_PACKER_OVERFLOW_CNT_EN
   logic [15:0] cnt_q;

   // Saturating count of dropped words.
   always_ff @(posedge CLK_I) begin
      if (RST_I)
         cnt_q <= 16'd0;
      else if (ovf_inc && (cnt_q != 16'hFFFF))
         cnt_q <= cnt_q + 16'd1;
   end

   assign OVERFLOW_CNT_O = cnt_q;
`endif

   assign STORE_O        = store_q;
   assign DATA_O         = data_q;
   assign TRG_EVENT_O    = trg_q;
   assign EVENT_POS_O    = evpos_q;
   assign LOAD_REQUEST_O = req_q;
   assign STREAM_O       = stream_q;
   assign STREAM_VALID_O = valid_q;
   assign OVERFLOW_O     = ovf_q;

endmodule

// File: tb/tb_trace_packer.sv
// Directed bench for trace_packer: packing, triggers, overflow, delay freeze,
// lane reconfiguration, reset discard and streaming handshake.
module tb_trace_packer;

   localparam int unsigned W  = 32;
   localparam int unsigned M  = 8;
   localparam int unsigned NB = 3;
   localparam int unsigned PW = $clog2(W);

   logic          CLK_I;
   logic          RST_I;
   logic          MODE_I;
   logic [NB-1:0] NTRACE_I;
   logic [M-1:0]  TRACE_I;
   logic          TRACE_VALID_I;
   logic          TRG_I;
   logic          TRG_DELAYED_I;
   logic          STORE_O;
   logic [W-1:0]  DATA_O;
   logic          STORE_PERM_I;
   logic          TRG_EVENT_O;
   logic [PW-1:0] EVENT_POS_O;
   logic          LOAD_REQUEST_O;
   logic          LOAD_GRANT_I;
   logic [W-1:0]  DATA_I;
   logic [M-1:0]  STREAM_O;
   logic          STREAM_VALID_O;
   logic          STREAM_READY_I;
   logic          OVERFLOW_O;
`ifdef TRACE_PACKER_OVERFLOW_CNT_EN
   logic [15:0]   OVERFLOW_CNT_O;
`endif

   int checks = 0;
   int errors = 0;

   trace_packer #(.TRB_WIDTH(W), .TRB_MAX_TRACES(M), .TRB_NTRACE_BITS(NB)) dut (
      .CLK_I(CLK_I), .RST_I(RST_I), .MODE_I(MODE_I), .NTRACE_I(NTRACE_I),
      .TRACE_I(TRACE_I), .TRACE_VALID_I(TRACE_VALID_I), .TRG_I(TRG_I),
      .TRG_DELAYED_I(TRG_DELAYED_I), .STORE_O(STORE_O), .DATA_O(DATA_O),
      .STORE_PERM_I(STORE_PERM_I), .TRG_EVENT_O(TRG_EVENT_O),
      .EVENT_POS_O(EVENT_POS_O), .LOAD_REQUEST_O(LOAD_REQUEST_O),
      .LOAD_GRANT_I(LOAD_GRANT_I), .DATA_I(DATA_I), .STREAM_O(STREAM_O),
      .STREAM_VALID_O(STREAM_VALID_O), .STREAM_READY_I(STREAM_READY_I),
      .OVERFLOW_O(OVERFLOW_O)
`ifdef TRACE_PACKER_OVERFLOW_CNT_EN
      , .OVERFLOW_CNT_O(OVERFLOW_CNT_O)
`endif
   );

   initial CLK_I = 1'b0;
   always #5 CLK_I = ~CLK_I;

   task automatic tick();
      @(posedge CLK_I);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] v, input logic trg);
      TRACE_I       = v;
      TRACE_VALID_I = 1'b1;
      TRG_I         = trg;
      tick();
      TRACE_VALID_I = 1'b0;
      TRG_I         = 1'b0;
   endtask

   initial begin
      RST_I = 1'b1; MODE_I = 1'b0; NTRACE_I = '0; TRACE_I = '0;
      TRACE_VALID_I = 1'b0; TRG_I = 1'b0; TRG_DELAYED_I = 1'b0;
      STORE_PERM_I = 1'b1; LOAD_GRANT_I = 1'b0; DATA_I = '0; STREAM_READY_I = 1'b0;
      tick(); tick();
      RST_I = 1'b0;
      chk("rst_store", 32'(STORE_O), 32'd0);
      chk("rst_data", DATA_O, 32'd0);
      chk("rst_trg", 32'(TRG_EVENT_O), 32'd0);
      chk("rst_evpos", 32'(EVENT_POS_O), 32'd0);
      chk("rst_req", 32'(LOAD_REQUEST_O), 32'd0);
      chk("rst_valid", 32'(STREAM_VALID_O), 32'd0);
      chk("rst_stream", 32'(STREAM_O), 32'd0);
      chk("rst_ovf", 32'(OVERFLOW_O), 32'd0);

      // L=1: alternating bits pack to 0x5555_5555
      for (int i = 0; i < 32; i++) begin
         send((i % 2 == 0) ? 8'h01 : 8'h00, 1'b0);
         if (i < 31) chk("l1_nostore", 32'(STORE_O), 32'd0);
      end
      chk("l1_store", 32'(STORE_O), 32'd1);
      chk("l1_data", DATA_O, 32'h5555_5555);
      tick();
      chk("l1_store_pulse", 32'(STORE_O), 32'd0);

      // L=8 with trigger on the third sample
      NTRACE_I = 3'd3; tick();
      send(8'h11, 1'b0);
      send(8'h22, 1'b0);
      chk("l8_trg_before", 32'(TRG_EVENT_O), 32'd0);
      send(8'h33, 1'b1);
      chk("l8_trg", 32'(TRG_EVENT_O), 32'd1);
      chk("l8_evpos", 32'(EVENT_POS_O), 32'd16);
      chk("l8_nostore", 32'(STORE_O), 32'd0);
      send(8'h44, 1'b0);
      chk("l8_store", 32'(STORE_O), 32'd1);
      chk("l8_data", DATA_O, 32'h4433_2211);
      chk("trace_req", 32'(LOAD_REQUEST_O), 32'd0);
      chk("trace_valid", 32'(STREAM_VALID_O), 32'd0);

      // L=4: first word dropped, second packed from bit 0, late trigger ignored
      NTRACE_I = 3'd2; tick();
      for (int i = 0; i < 8; i++) begin
         if (i == 7) STORE_PERM_I = 1'b0;
         send(8'(i + 1), 1'b0);
      end
      chk("l4_drop_store", 32'(STORE_O), 32'd0);
      chk("l4_ovf", 32'(OVERFLOW_O), 32'd1);
      chk("l4_data_kept", DATA_O, 32'h4433_2211);
`ifdef TRACE_PACKER_OVERFLOW_CNT_EN
      chk("l4_ovf_cnt", 32'(OVERFLOW_CNT_O), 32'd1);
`endif
      STORE_PERM_I = 1'b1;
      for (int i = 0; i < 8; i++) send(8'((i + 9) & 15), i == 0);
      chk("l4_store", 32'(STORE_O), 32'd1);
      chk("l4_data", DATA_O, 32'h0FED_CBA9);
      chk("l4_evpos_kept", 32'(EVENT_POS_O), 32'd16);
      chk("l4_ovf_sticky", 32'(OVERFLOW_O), 32'd1);

      // Delay freezes capture after three bytes
      NTRACE_I = 3'd3; tick();
      send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0);
      TRG_DELAYED_I = 1'b1;
      for (int i = 0; i < 4; i++) begin
         send(8'hFF, 1'b0);
         chk("dly_nostore", 32'(STORE_O), 32'd0);
      end
      TRG_DELAYED_I = 1'b0;
      send(8'h04, 1'b0);
      chk("dly_store", 32'(STORE_O), 32'd1);
      chk("dly_data", DATA_O, 32'h0403_0201);

      // Lane change mid-word discards the partial word
      NTRACE_I = 3'd2; tick();
      send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0);
      NTRACE_I = 3'd3; tick();
      send(8'h55, 1'b0); send(8'h66, 1'b0); send(8'h77, 1'b0);
      chk("chg_nostore", 32'(STORE_O), 32'd0);
      send(8'h88, 1'b0);
      chk("chg_store", 32'(STORE_O), 32'd1);
      chk("chg_data", DATA_O, 32'h8877_6655);

      // Reset mid-word clears flags and the partial word
      send(8'hAB, 1'b0); send(8'hCD, 1'b0);
      RST_I = 1'b1; tick(); RST_I = 1'b0;
      chk("mrst_trg", 32'(TRG_EVENT_O), 32'd0);
      chk("mrst_ovf", 32'(OVERFLOW_O), 32'd0);
      chk("mrst_data", DATA_O, 32'd0);
      send(8'h10, 1'b0); send(8'h20, 1'b0); send(8'h30, 1'b0); send(8'h40, 1'b0);
      chk("mrst_store", 32'(STORE_O), 32'd1);
      chk("mrst_word", DATA_O, 32'h4030_2010);

      // Streaming L=8 with a stall on the second sample
      MODE_I = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (LOAD_REQUEST_O) break;
      end
      chk("st_req", 32'(LOAD_REQUEST_O), 32'd1);
      chk("st_valid_idle", 32'(STREAM_VALID_O), 32'd0);
      LOAD_GRANT_I = 1'b1; DATA_I = 32'hDEAD_BEEF;
      tick();
      chk("st_req_pulse", 32'(LOAD_REQUEST_O), 32'd0);
      chk("st_early_grant", 32'(STREAM_VALID_O), 32'd0);
      DATA_I = 32'hDDCC_BBAA;
      tick();
      LOAD_GRANT_I = 1'b0;
      chk("st_valid", 32'(STREAM_VALID_O), 32'd1);
      chk("st_aa", 32'(STREAM_O), 32'hAA);
      STREAM_READY_I = 1'b1; tick();
      chk("st_bb", 32'(STREAM_O), 32'hBB);
      STREAM_READY_I = 1'b0; tick();
      chk("st_bb_hold", 32'(STREAM_O), 32'hBB);
      chk("st_valid_hold", 32'(STREAM_VALID_O), 32'd1);
      STREAM_READY_I = 1'b1; tick();
      chk("st_cc", 32'(STREAM_O), 32'hCC);
      tick();
      chk("st_dd", 32'(STREAM_O), 32'hDD);
      chk("st_nostore", 32'(STORE_O), 32'd0);
      tick();
      STREAM_READY_I = 1'b0;
      chk("st_end_valid", 32'(STREAM_VALID_O), 32'd0);
      chk("st_rereq", 32'(LOAD_REQUEST_O), 32'd1);
      tick();
      chk("st_rereq_pulse", 32'(LOAD_REQUEST_O), 32'd0);
      chk("st_wait_valid", 32'(STREAM_VALID_O), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
